// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft
//   Single-clock FIFO over an inferred RAM of 2^DEPTH_WIDTH words, with a
//   selectable read mode:
//     FWFT=0 : rd_data/rd_valid arrive one cycle after an accepted rd_en.
//     FWFT=1 : the head word sits on rd_data whenever the FIFO is not empty,
//              and rd_en pops it.
//   water_level counts every stored word, including the one presented in
//   FWFT mode. All status flags are registered from the post-edge level.
//   overflow/underflow are sticky until clr_err or rst.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   wr_en, wr_data        write request and data
//   wr_full, almost_full  level == DEPTH, level >= ALMOST_FULL_NUM
//   rd_en                 read request (standard) or pop (FWFT)
//   rd_data, rd_valid     read data and its qualifier
//   rd_empty, almost_empty level == 0, level <= ALMOST_EMPTY_NUM
//   water_level           stored words, 0..DEPTH
//   overflow, underflow   sticky error flags
//   clr_err               clears both error flags
module sync_fifo_fwft #(
  parameter int DATA_WIDTH       = 8,
  parameter int DEPTH_WIDTH      = 8,
  parameter int FWFT             = 0,
  parameter int ALMOST_FULL_NUM  = 252,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_empty,
  output logic                  almost_empty,
  output logic [DEPTH_WIDTH:0]  water_level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int               DEPTH   = 1 << DEPTH_WIDTH;
  localparam int               LW      = DEPTH_WIDTH + 1;
  localparam logic [LW-1:0]    LVL_MAX = LW'(DEPTH);
  localparam logic [LW-1:0]    LVL_AF  = LW'(ALMOST_FULL_NUM);
  localparam logic [LW-1:0]    LVL_AE  = LW'(ALMOST_EMPTY_NUM);

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                   wr_acc, rd_acc;
  logic [LW-1:0]          lvl_nxt;

  // Accept decisions use the registered flags; a full FIFO rejects writes
  // even when a read frees a slot on the same edge.
  assign wr_acc  = wr_en && !wr_full;
  assign rd_acc  = rd_en && !rd_empty;
  assign lvl_nxt = water_level + LW'(wr_acc) - LW'(rd_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      water_level  <= '0;
      wr_full      <= 1'b0;
      almost_full  <= 1'b0;
      rd_empty     <= 1'b1;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + DEPTH_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + DEPTH_WIDTH'(1);
      water_level  <= lvl_nxt;
      wr_full      <= (lvl_nxt == LVL_MAX);
      almost_full  <= (lvl_nxt >= LVL_AF);
      rd_empty     <= (lvl_nxt == '0);
      almost_empty <= (lvl_nxt <= LVL_AE);
      // A new error event wins over a coincident clear.
      overflow     <= (wr_en && wr_full)  || (overflow  && !clr_err);
      underflow    <= (rd_en && rd_empty) || (underflow && !clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // The RAM is read every cycle at the post-edge head address, so its
      // registered output always holds the head word one edge later. The
      // only case the RAM cannot cover is when the new head is the word
      // being written on this same edge (read-before-write); that word is
      // captured in byp_q and muxed in instead.
      logic [DEPTH_WIDTH-1:0] rd_ptr_nxt;
      logic [DATA_WIDTH-1:0]  ram_q, byp_q;
      logic                   byp_hit, byp_sel;

      assign rd_ptr_nxt = rd_ptr + DEPTH_WIDTH'(rd_acc);
      assign byp_hit    = wr_acc && (wr_ptr == rd_ptr_nxt);

      always_ff @(posedge clk) begin
        ram_q <= mem[rd_ptr_nxt];
      end

      // Reset selects a zeroed bypass register so rd_data reads 0.
      always_ff @(posedge clk) begin
        if (rst) begin
          byp_sel <= 1'b1;
          byp_q   <= '0;
        end else begin
          byp_sel <= byp_hit;
          if (byp_hit) byp_q <= wr_data;
        end
      end

      assign rd_data  = byp_sel ? byp_q : ram_q;
      assign rd_valid = !rd_empty;
    end else begin : g_std
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_acc;
          if (rd_acc) rd_data <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
- Single-clock, parametrised FIFO and the next generation of the team's FIFO wrapper.
- Adds a selectable first-word-fall-through (FWFT) read mode, a read-valid strobe, a word count, and sticky overflow/underflow error flags.
- Storage is an inferred RAM of 2^DEPTH_WIDTH words.
- Used for same-clock rate decoupling between pipeline stages and for bridging to the async FIFO IP.

Parameters:
- DATA_WIDTH, 8: data width in bits, legal 1..1152.
- DEPTH_WIDTH, 8: log2 of depth; capacity DEPTH = 2^DEPTH_WIDTH words, legal 2..20.
- FWFT, 0: 0 = standard read (data one cycle after rd_en); 1 = head word presented before rd_en.
- ALMOST_FULL_NUM, 252: almost_full asserts when level >= this value, legal 1..DEPTH.
- ALMOST_EMPTY_NUM, 4: almost_empty asserts when level <= this value, legal 0..DEPTH-1.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high; one clk edge with rst=1 resets the block.
- wr_en  input  1  write request.
- wr_data  input  DATA_WIDTH  write data.
- wr_full  output  1  FIFO full.
- almost_full  output  1  level >= ALMOST_FULL_NUM.
- rd_en  input  1  read request (standard mode) or pop (FWFT mode).
- rd_data  output  DATA_WIDTH  read data.
- rd_valid  output  1  rd_data is valid this cycle.
- rd_empty  output  1  FIFO empty.
- almost_empty  output  1  level <= ALMOST_EMPTY_NUM.
- water_level  output  DEPTH_WIDTH+1  number of stored words, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.
- clr_err  input  1  clears overflow and underflow.

Behaviour:
- Reset values:
  - water_level=0, rd_empty=1, almost_empty=1.
  - wr_full=0, almost_full=0.
  - rd_valid=0, rd_data=0.
  - overflow=0, underflow=0.
  - Both pointers=0.
  - Reset mid-operation discards all contents; the outputs take these values on the next cycle.
- Accept rules:
  - A write is accepted when wr_en && !wr_full.
  - A read is accepted when rd_en && !rd_empty.
  - Flags use their registered values from the current cycle.
- Full boundary: when full, a write is always rejected, even if a read is accepted in the same cycle. The read proceeds and the level drops by 1.
- Empty boundary: when empty, rd_en is ignored. A write arriving in that same cycle is accepted.
- Level update:
  - Write only: +1.
  - Read only: -1.
  - Write and read both accepted: level unchanged.
  - No saturation arithmetic is needed; the accept rules keep the level within 0..DEPTH.
- Pointers: DEPTH_WIDTH bits each, wrapping naturally modulo DEPTH. Full and empty are derived from water_level, not from pointer compare.
- Flag timing:
  - All status flags are registered and reflect the level after the cycle's events, one edge later.
  - wr_full = (level==DEPTH). rd_empty = (level==0).
  - almost_full and almost_empty follow their thresholds.
- Standard mode (FWFT=0):
  - For a read accepted at edge N, rd_data is driven with the head word and rd_valid=1 during cycle N+1.
  - rd_valid is 0 in every other cycle.
  - rd_data holds its last value when no read is accepted.
- FWFT mode (FWFT=1):
  - While rd_empty=0, rd_data shows the head word and rd_valid=1.
  - rd_en pops the word, and the next word (if any) appears in the following cycle.
  - A word written into an empty FIFO at edge N appears at edge N+1, with rd_empty=0 and rd_valid=1 at the same time.
  - Capacity stays DEPTH, and water_level includes the presented word.
  - rd_valid always equals !rd_empty.
- Data ordering: strict FIFO order; no word is lost or duplicated across pointer wrap.
- Error flags:
  - overflow is set on wr_en && wr_full. underflow is set on rd_en && rd_empty.
  - Both hold until clr_err or rst.
  - If clr_err coincides with a new error event, the flag stays set.
  - Rejected operations do not change the level, the pointers or the data.
- RAM read latency: one cycle (block-RAM inferable). In FWFT mode, a prefetch/bypass register is required to meet the FWFT timing above.

Test Plan:
- Bench configuration: DEPTH_WIDTH=4 (DEPTH=16), DATA_WIDTH=8, ALMOST_FULL_NUM=14, ALMOST_EMPTY_NUM=2, run for both FWFT=0 and FWFT=1.
1. Reset then fill: write 0x00..0x0F on 16 consecutive cycles.
   - water_level counts 1..16.
   - almost_empty drops after the 3rd write; almost_full rises after the 14th write.
   - wr_full=1 after the 16th write.
   - A 17th write with value 0xAA is rejected, level stays 16, and overflow=1 stays set.
2. Drain, standard mode: rd_en for 16 cycles.
   - rd_data is 0x00..0x0F, each with rd_valid=1 one cycle after its rd_en.
   - rd_empty=1 after the last read.
   - An extra rd_en sets underflow=1 and rd_valid stays 0.
3. FWFT timing: write 0x5A into an empty FIFO.
   - On the next cycle, rd_empty=0, rd_valid=1 and rd_data=0x5A with no rd_en.
   - Pulse rd_en: the cycle after, rd_empty=1 and water_level=0.
4. Simultaneous read and write at level 8 for 40 cycles with an incrementing pattern.
   - water_level stays 8, the data sequence is contiguous, and the pointers wrap twice without error.
5. Full plus simultaneous traffic: at level 16, assert wr_en and rd_en together.
   - The read is accepted, the write is rejected, the level becomes 15, and overflow=1.
   - Assert clr_err together with another wr_en while full: overflow stays 1.
   - Assert clr_err alone: overflow=0.
6. Reset mid-operation: at level 9, assert rst for one cycle.
   - Next cycle: water_level=0, rd_empty=1, flags at their reset values.
   - A subsequent write of 0x33 then a read returns 0x33.
